// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one partial-product step per clock through a
// ripple-carry adder, with a start/busy/done handshake. Includes the rpc_adder it builds on.

module rpc_adder #(
   parameter int unsigned NR_BITS = 4
) (
   input  logic [NR_BITS-1:0] a,
   input  logic [NR_BITS-1:0] b,
   input  logic               c_in,
   output logic [NR_BITS-1:0] sum,
   output logic               c_out
);

   logic [NR_BITS:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < NR_BITS; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c_out = carry[NR_BITS];

endmodule

module seq_multiplier #(
   parameter int unsigned NR_BITS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NR_BITS-1:0]     a,
   input  logic [NR_BITS-1:0]     b,
   output logic [2*NR_BITS-1:0]   product,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned CntW = $clog2(NR_BITS + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q, state_d;
   logic [NR_BITS-1:0]     mcand_q, mcand_d;
   logic [2*NR_BITS-1:0]   acc_q, acc_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [2*NR_BITS-1:0]   product_q, product_d;

   logic [NR_BITS-1:0]     add_b;
   logic [NR_BITS-1:0]     sum;
   logic                   c_out;
   logic [2*NR_BITS-1:0]   shifted;

   assign add_b = acc_q[0] ? mcand_q : '0;

   rpc_adder #(
      .NR_BITS (NR_BITS)
   ) u_adder (
      .a     (acc_q[2*NR_BITS-1:NR_BITS]),
      .b     (add_b),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (c_out)
   );

   // {c_out, sum, lo} >> 1 with the dropped LSB; c_out lands in the MSB of hi.
   assign shifted = {c_out, sum, acc_q[NR_BITS-1:1]};

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               mcand_d = a;
               acc_d   = {{NR_BITS{1'b0}}, b};
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            acc_d = shifted;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(NR_BITS - 1)) begin
               product_d = shifted;
               state_d   = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;
   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: NR_BITS=4 and NR_BITS=8 instances checked against plain a*b
// and the start-to-done timing rules.

module tb_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic [7:0]  product4;
   logic [15:0] product8;
   logic        busy4, done4, busy8, done8;

   int checks = 0;
   int errors = 0;

   seq_multiplier #(.NR_BITS(4)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start4),
      .a       (a4),
      .b       (b4),
      .product (product4),
      .busy    (busy4),
      .done    (done4)
   );

   seq_multiplier #(.NR_BITS(8)) u_dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start8),
      .a       (a8),
      .b       (b8),
      .product (product8),
      .busy    (busy8),
      .done    (done8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One start pulse; returns product at the done pulse, busy cycles seen, and the
   // negedge index (after the accepting edge) where done appeared (0 = never).
   task automatic do_op(input bit wide, input logic [7:0] xa, input logic [7:0] xb,
                        output logic [15:0] prod, output int nbusy, output int lat);
      @(posedge clk); #1;
      if (wide) begin
         start8 = 1'b1; a8 = xa; b8 = xb;
      end else begin
         start4 = 1'b1; a4 = xa[3:0]; b4 = xb[3:0];
      end
      @(posedge clk); #1;
      start4 = 1'b0;
      start8 = 1'b0;
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      nbusy = 0;
      lat   = 0;
      prod  = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (wide ? busy8 : busy4) nbusy++;
         if (wide ? done8 : done4) begin
            lat  = i;
            prod = wide ? product8 : {8'h00, product4};
            break;
         end
      end
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [15:0] prod;
      logic [7:0]  ra, rb;
      int          nbusy, lat, ndone, gap, t1, t2;
      logic [15:0] p1, p2;
      bit          held;

      vecs[0] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
      vecs[1] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0};
      vecs[2] = '{a: 4'd7,  b: 4'd0,  exp: 8'd0};
      vecs[3] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1};
      vecs[4] = '{a: 4'd15, b: 4'd1,  exp: 8'd15};
      vecs[5] = '{a: 4'd2,  b: 4'd14, exp: 8'd28};

      rst_n = 1'b0;
      start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      check("reset_product4", 32'(product4), 0);
      check("reset_busy4", 32'(busy4), 0);
      check("reset_done4", 32'(done4), 0);
      check("reset_product8", 32'(product8), 0);
      rst_n = 1'b1;

      // 13*11 with timing, then hold for 10 idle cycles
      do_op(1'b0, 8'd13, 8'd11, prod, nbusy, lat);
      check("op13x11_product", 32'(prod), 143);
      check("op13x11_busy_cycles", 32'(nbusy), 4);
      check("op13x11_latency", 32'(lat), 5);
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (product4 !== 8'd143 || done4 || busy4) held = 1'b0;
      end
      check("op13x11_hold", 32'(held), 1);

      foreach (vecs[i]) begin
         do_op(1'b0, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, prod, nbusy, lat);
         check($sformatf("vec%0d_product", i), 32'(prod), 32'(vecs[i].exp));
         check($sformatf("vec%0d_latency", i), 32'(lat), 5);
      end

      // start re-asserted during RUN must be ignored
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
      @(posedge clk); #1;
      start4 = 1'b0;
      ndone = 0; p1 = '0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done4) begin
            ndone++;
            if (ndone == 1) p1 = {8'h00, product4};
         end
      end
      check("ignore_start_product", 32'(p1), 15);
      check("ignore_start_done_count", 32'(ndone), 1);

      // start held high: back-to-back 6*7 then 2*3 presented in the DONE cycle
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      a4 = 4'd2; b4 = 4'd3;
      ndone = 0; gap = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (!busy4 && !done4) gap = 1;
         if (done4) begin
            ndone++;
            if (ndone == 1) begin
               t1 = i; p1 = {8'h00, product4};
            end else begin
               t2 = i; p2 = {8'h00, product4};
               start4 = 1'b0;
               break;
            end
         end
      end
      check("b2b_first_product", 32'(p1), 42);
      check("b2b_second_product", 32'(p2), 6);
      check("b2b_done_spacing", 32'(t2 - t1), 5);
      check("b2b_no_gap", 32'(gap), 0);
      repeat (2) @(negedge clk);
      check("b2b_back_to_idle", 32'({busy4, done4}), 0);

      // asynchronous reset two steps into 12*12
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd12; b4 = 4'd12;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrun_reset_busy", 32'(busy4), 0);
      check("midrun_reset_done", 32'(done4), 0);
      check("midrun_reset_product", 32'(product4), 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b0, 8'd5, 8'd5, prod, nbusy, lat);
      check("after_reset_5x5", 32'(prod), 25);

      // NR_BITS=8
      do_op(1'b1, 8'd255, 8'd255, prod, nbusy, lat);
      check("w8_255x255_product", 32'(prod), 65025);
      check("w8_255x255_latency", 32'(lat), 9);
      check("w8_255x255_busy_cycles", 32'(nbusy), 8);

      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         do_op(1'b1, ra, rb, prod, nbusy, lat);
         check($sformatf("w8_rand%0d_%0dx%0d", n, ra, rb), 32'(prod), 32'(16'(ra) * 16'(rb)));
         check($sformatf("w8_rand%0d_latency", n), 32'(lat), 9);
      end

      for (int n = 0; n < 100; n++) begin
         ra = 8'($urandom_range(15, 0));
         rb = 8'($urandom_range(15, 0));
         do_op(1'b0, ra, rb, prod, nbusy, lat);
         check($sformatf("w4_rand%0d_%0dx%0d", n, ra, rb), 32'(prod), 32'(ra * rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
